// File: rtl/jpeg_pkg.sv
// ============================================================================
// Module      : jpeg_pkg
// Description : Shared JPEG constants: block size and zigzag scan table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpeg_pkg;

    localparam int BLK_SZ = 64;
    localparam int BLK_AW = 6;

    // Entry k holds the raster address (row*8+col) of zigzag index k.
    localparam logic [0:BLK_SZ-1][BLK_AW-1:0] ZZ_TABLE = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [BLK_AW-1:0] zz_addr(input logic [BLK_AW-1:0] idx);
        return ZZ_TABLE[idx];
    endfunction

endpackage

`default_nettype wire

// File: rtl/zigzag_buf_if.sv
// ============================================================================
// Module      : zigzag_buf_if
// Description : Raster sample input and zigzag coefficient output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface zigzag_buf_if #(
    parameter int DIN_W = 8
);
    logic signed [DIN_W-1:0] din;
    logic                    din_valid;
    logic signed [DIN_W:0]   dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_first;
    logic                    dout_last;
    logic                    overflow;

    // master: sample source / coefficient sink; slave: the buffer itself
    modport master (
        output din, din_valid, dout_ready,
        input  dout, dout_valid, dout_first, dout_last, overflow
    );
    modport slave (
        input  din, din_valid, dout_ready,
        output dout, dout_valid, dout_first, dout_last, overflow
    );
endinterface

`default_nettype wire

// File: rtl/zigzag_ram.sv
// ============================================================================
// Module      : zigzag_ram
// Description : Two 64-entry coefficient banks, one write port and one
//               registered (enabled) read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zigzag_ram
    import jpeg_pkg::*;
#(
    parameter int DIN_W = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic              i_wr_bank,
    input  logic [BLK_AW-1:0] i_wr_addr,
    input  logic [DIN_W-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic              i_rd_bank,
    input  logic [BLK_AW-1:0] i_rd_addr,
    output logic [DIN_W-1:0]  o_rd_data
);

    logic [DIN_W-1:0] r_mem [0:2*BLK_SZ-1];
    logic [DIN_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
        // Read data holds while the downstream pipeline is stalled.
        if (i_rd_en) begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/zigzag_buf.sv
// ============================================================================
// Module      : zigzag_buf
// Description : Ping-pong 8x8 block buffer, raster in / zigzag out, with
//               ready/valid output. Optional DC differencing: ZIGZAG_DC_DIFF_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zigzag_buf
    import jpeg_pkg::*;
#(
    parameter int DIN_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    zigzag_buf_if.slave  zz
);

    localparam logic [BLK_AW-1:0] c_LAST_IDX = 6'd63;

    logic [BLK_AW-1:0] r_wr_cnt;
    logic              r_wr_sel;
    logic [1:0]        r_full;
    logic [BLK_AW-1:0] r_rd_cnt;
    logic              r_rd_sel;
    logic              r_s1_valid;
    logic [BLK_AW-1:0] r_s1_idx;
    logic              r_out_sel;
    logic              r_dout_valid;
    logic [DIN_W:0]    r_dout;
    logic              r_first;
    logic              r_last;
    logic              r_overflow;

    logic              w_wr_en;
    logic              w_drop;
    logic              w_wr_done;
    logic              w_xfer;
    logic              w_s2_load;
    logic              w_s1_free;
    logic              w_rd_en;
    logic              w_rd_done;
    logic              w_clr;
    logic [1:0]        w_full_nxt;
    logic [DIN_W-1:0]  w_rd_data;
    logic [DIN_W:0]    w_ext;
    logic [DIN_W:0]    w_dout_nxt;

    assign w_wr_en   = zz.din_valid & ~r_full[r_wr_sel];
    assign w_drop    = zz.din_valid &  r_full[r_wr_sel];
    assign w_wr_done = w_wr_en & (r_wr_cnt == c_LAST_IDX);

    // Two-stage read pipeline: RAM read register, then the dout register.
    assign w_xfer    = r_dout_valid & zz.dout_ready;
    assign w_s2_load = r_s1_valid & (~r_dout_valid | zz.dout_ready);
    assign w_s1_free = ~r_s1_valid | w_s2_load;
    assign w_rd_en   = r_full[r_rd_sel] & w_s1_free;
    assign w_rd_done = w_rd_en & (r_rd_cnt == c_LAST_IDX);
    assign w_clr     = w_xfer & r_last;

    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
        if (w_clr) begin
            w_full_nxt[r_out_sel] = 1'b0;
        end
    end

    zigzag_ram #(
        .DIN_W (DIN_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (r_wr_sel),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (zz.din),
        .i_rd_en   (w_rd_en),
        .i_rd_bank (r_rd_sel),
        .i_rd_addr (zz_addr(r_rd_cnt)),
        .o_rd_data (w_rd_data)
    );

    assign w_ext = {w_rd_data[DIN_W-1], w_rd_data};

`ifdef ZIGZAG_DC_DIFF_EN
    logic [DIN_W-1:0] r_pred;
    logic [DIN_W-1:0] r_dc_hold;

    // One extra bit makes the DC difference exact for any pair of inputs.
    assign w_dout_nxt = (r_s1_idx == '0) ? (w_ext - {r_pred[DIN_W-1], r_pred}) : w_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred    <= '0;
            r_dc_hold <= '0;
        end else begin
            if (w_s2_load && (r_s1_idx == '0)) begin
                r_dc_hold <= w_rd_data;
            end
            if (w_xfer && r_first) begin
                r_pred <= r_dc_hold;
            end
        end
    end
`else
    assign w_dout_nxt = w_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt     <= '0;
            r_wr_sel     <= 1'b0;
            r_full       <= '0;
            r_rd_cnt     <= '0;
            r_rd_sel     <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_idx     <= '0;
            r_out_sel    <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + 6'd1;
            end
            if (w_wr_done) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + 6'd1;
                r_s1_idx <= r_rd_cnt;
            end
            if (w_rd_done) begin
                r_rd_sel <= ~r_rd_sel;
            end
            if (w_rd_en) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_load) begin
                r_dout_valid <= 1'b1;
                r_dout       <= w_dout_nxt;
                r_first      <= (r_s1_idx == '0);
                r_last       <= (r_s1_idx == c_LAST_IDX);
            end else if (w_xfer) begin
                r_dout_valid <= 1'b0;
                r_first      <= 1'b0;
                r_last       <= 1'b0;
            end
            // Banks drain in the order they filled, so a toggle tracks the source.
            if (w_clr) begin
                r_out_sel <= ~r_out_sel;
            end
        end
    end

    assign zz.dout       = r_dout;
    assign zz.dout_valid = r_dout_valid;
    assign zz.dout_first = r_first;
    assign zz.dout_last  = r_last;
    assign zz.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_zigzag_buf.sv
// ============================================================================
// Module      : tb_zigzag_buf
// Description : Self-checking bench for zigzag_buf (honours ZIGZAG_DC_DIFF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zigzag_buf;

    localparam int DIN_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zigzag_buf_if #(.DIN_W(DIN_W)) zif ();

    zigzag_buf #(.DIN_W(DIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .zz  (zif.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference zigzag order derived by walking the anti-diagonals of the 8x8 block.
    int zz_ref[64];
    initial begin
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz_ref[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz_ref[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    end

    // Behavioural model: a bank is busy from block completion until its last output leaves.
    int   exp_q[$];
    int   partial[$];
    int   out_idx = 0;
    int   pending = 0;
    int   pred = 0;
    logic ov_exp = 1'b0;
    logic prev_stall = 1'b0;
    int   prev_dout = 0;

    always @(negedge clk) begin
        int pend0;
        int v;
        if (rst) begin
            exp_q.delete();
            partial.delete();
            out_idx    = 0;
            pending    = 0;
            pred       = 0;
            ov_exp     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            pend0 = pending;
            chk("overflow", int'(zif.overflow), int'(ov_exp));
            if (prev_stall) begin
                chk("hold_valid", int'(zif.dout_valid), 1);
                chk("hold_data", int'($signed(zif.dout)), prev_dout);
            end
            if (zif.dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("first_flag", int'(zif.dout_first), int'(out_idx == 0));
                    chk("last_flag", int'(zif.dout_last), int'(out_idx == 63));
                    if (zif.dout_ready) begin
                        chk("dout", int'($signed(zif.dout)), exp_q[0]);
                        void'(exp_q.pop_front());
                        out_idx++;
                        if (out_idx == 64) begin
                            out_idx = 0;
                            pending--;
                        end
                    end
                end
            end
            prev_stall = zif.dout_valid && !zif.dout_ready;
            prev_dout  = int'($signed(zif.dout));
            if (zif.din_valid) begin
                if (pend0 == 2) begin
                    ov_exp = 1'b1;
                end else begin
                    partial.push_back(int'($signed(zif.din)));
                    if (partial.size() == 64) begin
                        for (int k = 0; k < 64; k++) begin
                            v = partial[zz_ref[k]];
`ifdef ZIGZAG_DC_DIFF_EN
                            if (k == 0) begin
                                v    = partial[0] - pred;
                                pred = partial[0];
                            end
`endif
                            exp_q.push_back(v);
                        end
                        partial.delete();
                        pending++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        zif.din       = v[DIN_W-1:0];
        zif.din_valid = 1'b1;
        tick();
        zif.din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit do_rst;
        int dc;
        int ac;
        int exp_dc;
        int exp_ac;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        int got[64];
        int cnt;
        int bad;

        vecs[0] = '{do_rst: 1'b1, dc: -5,   ac: -5, exp_dc: -5,   exp_ac: -5};
`ifdef ZIGZAG_DC_DIFF_EN
        vecs[1] = '{do_rst: 1'b0, dc: -5,   ac: -5, exp_dc: 0,    exp_ac: -5};
        vecs[2] = '{do_rst: 1'b1, dc: 127,  ac: 3,  exp_dc: 127,  exp_ac: 3};
        vecs[3] = '{do_rst: 1'b0, dc: -128, ac: -1, exp_dc: -255, exp_ac: -1};
`else
        vecs[1] = '{do_rst: 1'b0, dc: -5,   ac: -5, exp_dc: -5,   exp_ac: -5};
        vecs[2] = '{do_rst: 1'b1, dc: 127,  ac: 3,  exp_dc: 127,  exp_ac: 3};
        vecs[3] = '{do_rst: 1'b0, dc: -128, ac: -1, exp_dc: -128, exp_ac: -1};
`endif

        zif.din        = '0;
        zif.din_valid  = 1'b0;
        zif.dout_ready = 1'b1;
        do_reset();

        chk("rst_dout_valid", int'(zif.dout_valid), 0);
        chk("rst_dout", int'($signed(zif.dout)), 0);
        chk("rst_first", int'(zif.dout_first), 0);
        chk("rst_last", int'(zif.dout_last), 0);
        chk("rst_overflow", int'(zif.overflow), 0);

        // Raster ramp: latency and the opening of the zigzag sequence.
        for (int i = 0; i < 64; i++) send(i);
        chk("lat_t0_valid", int'(zif.dout_valid), 0);
        tick();
        chk("lat_t1_valid", int'(zif.dout_valid), 0);
        tick();
        chk("lat_t2_valid", int'(zif.dout_valid), 1);
        chk("lat_t2_dout", int'($signed(zif.dout)), 0);
        chk("lat_t2_first", int'(zif.dout_first), 1);
        tick();
        chk("ramp_idx1", int'($signed(zif.dout)), 1);
        tick();
        chk("ramp_idx2", int'($signed(zif.dout)), 8);
        tick();
        chk("ramp_idx3", int'($signed(zif.dout)), 16);
        repeat (70) tick();
        chk("ramp_drained", exp_q.size(), 0);

        // Two back-to-back blocks must stream out with no gap.
        fork
            begin
                for (int i = 0; i < 128; i++) send(int'($urandom_range(0, 255)));
            end
            begin
                int t;
                int gaps;
                t = 0;
                while (!zif.dout_valid && t < 300) begin
                    tick();
                    t++;
                end
                chk("b2b_start_timeout", int'(t < 300), 1);
                gaps = 0;
                for (int i = 0; i < 128; i++) begin
                    if (!zif.dout_valid) gaps++;
                    tick();
                end
                chk("b2b_gaps", gaps, 0);
            end
        join
        chk("b2b_overflow", int'(zif.overflow), 0);
        repeat (10) tick();

        // Downstream stall mid-block.
        for (int i = 0; i < 64; i++) send(i * 3 - 90);
        repeat (6) tick();
        zif.dout_ready = 1'b0;
        tick();
        held = int'($signed(zif.dout));
        repeat (10) tick();
        chk("stall_valid", int'(zif.dout_valid), 1);
        chk("stall_hold", int'($signed(zif.dout)), held);
        zif.dout_ready = 1'b1;
        repeat (80) tick();
        chk("stall_drained", exp_q.size(), 0);

        // Three blocks against a blocked sink: third block dropped.
        zif.dout_ready = 1'b0;
        for (int i = 0; i < 192; i++) begin
            send(int'($urandom_range(0, 255)));
            if (i == 127) chk("ovf_at_127", int'(zif.overflow), 0);
            if (i == 128) chk("ovf_at_128", int'(zif.overflow), 1);
        end
        chk("ovf_end", int'(zif.overflow), 1);
        zif.dout_ready = 1'b1;
        repeat (200) tick();
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_sticky", int'(zif.overflow), 1);
        do_reset();
        chk("ovf_cleared", int'(zif.overflow), 0);

        // Partial block, then reset, then the table of DC/AC blocks.
        for (int i = 0; i < 30; i++) send(77);
        foreach (vecs[v]) begin
            if (vecs[v].do_rst) do_reset();
            for (int i = 0; i < 64; i++) send(i == 0 ? vecs[v].dc : vecs[v].ac);
            cnt = 0;
            for (int t = 0; t < 200 && cnt < 64; t++) begin
                if (zif.dout_valid) begin
                    got[cnt] = int'($signed(zif.dout));
                    cnt++;
                end
                tick();
            end
            chk($sformatf("vec%0d_count", v), cnt, 64);
            chk($sformatf("vec%0d_dc", v), got[0], vecs[v].exp_dc);
            bad = 0;
            for (int i = 1; i < 64; i++) if (got[i] != vecs[v].exp_ac) bad++;
            chk($sformatf("vec%0d_ac_bad", v), bad, 0);
        end

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            zif.din        = DIN_W'($urandom);
            zif.din_valid  = ($urandom_range(0, 99) < 70);
            zif.dout_ready = (c % 1000 < 700) ? ($urandom_range(0, 99) < 85)
                                              : ($urandom_range(0, 99) < 20);
            tick();
        end
        zif.din_valid  = 1'b0;
        zif.dout_ready = 1'b1;
        repeat (200) tick();
        chk("rand_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/zigzag_buf.md
ZIGZAG_BUF -- requirements
Module: zigzag_buf

Interface
REQ-001 SHALL have parameter: DIN_W, default 8, signed quantized coefficient width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: din  input  DIN_W  signed two's-complement coefficient, raster order (index = row*8+col).
REQ-005 SHALL have port: din_valid  input  1  din is present this cycle; upstream has no backpressure.
REQ-006 SHALL have port: dout  output  DIN_W+1  signed coefficient in zigzag order.
REQ-007 SHALL have port: dout_valid  output  1  dout is present.
REQ-008 SHALL have port: dout_ready  input  1  downstream accepts dout this cycle.
REQ-009 SHALL have port: dout_first  output  1  dout is zigzag index 0 (DC).
REQ-010 SHALL have port: dout_last  output  1  dout is zigzag index 63.
REQ-011 SHALL have port: overflow  output  1  sticky; an input sample was dropped.

Function
REQ-012 SHALL buffer 8x8 blocks in two 64-entry banks (ping-pong); write bank and read bank alternate per block.
REQ-013 SHALL write each din_valid sample to address wr_cnt of the write bank; wr_cnt 0..63, wraps to 0 after 63.
REQ-014 SHALL mark the write bank full and toggle the write bank select on the cycle that sample 63 is written.
REQ-015 SHALL read the full bank at address ZZ[rd_cnt], rd_cnt 0..63, advancing only on a transfer (dout_valid & dout_ready) or while the output register is empty.
REQ-016 SHALL register dout; dout holds and dout_valid stays high while dout_ready is low.
REQ-017 SHALL, with sample 63 accepted at cycle T and the read side idle with dout_ready high, present zigzag index 0 at T+2.
REQ-018 SHALL clear a bank's full flag when its index 63 transfers; read then moves to the other bank without bubble if that bank is full.
REQ-019 SHALL handle a bank going full and the other bank emptying on the same cycle with both flag updates taking effect.
REQ-020 SHALL, when din_valid arrives and the write bank is still full (both banks full), drop the sample, hold wr_cnt, and set overflow until reset.
REQ-021 SHALL sign-extend din to DIN_W+1 on output for all indices except as REQ-026 states.
REQ-022 SHALL assert dout_first with index 0 and dout_last with index 63; both are qualified by dout_valid.
REQ-023 SHALL sustain one coefficient per cycle with dout_ready held high: 64 samples in, 64 out, no stall.

Reset
REQ-024 SHALL, on rst: dout_valid=0, dout=0, dout_first=0, dout_last=0, overflow=0, wr_cnt=0, rd_cnt=0, both banks empty, both bank selects=0, DC predictor=0.
REQ-025 SHALL discard a partial block on reset mid-operation; bank RAM contents need not be cleared.

Configuration
REQ-026 SHALL, with ZIGZAG_DC_DIFF_EN defined, output index 0 as DC minus previous block's DC (DIN_W+1 bits, exact); predictor updates on index-0 transfer. Without the macro, DC passes through sign-extended and no predictor register exists.

Structure
REQ-027 SHALL take the 64-entry zigzag table (6-bit raster addresses) and the BLK_SZ=64 constant from the shared jpeg_pkg package.
REQ-028 SHALL place bank storage in one sub-module, zigzag_ram (2x64xDIN_W, one write port, one registered read port).

Verification
REQ-029 SHALL check: din = 0..63 (raster index as value), dout_ready=1 -> dout sequence 0,1,8,16,9,2,3,10,...,63; first at T+2; first/last on 0 and 63.
REQ-030 SHALL check: two back-to-back blocks, dout_ready=1 -> 128 outputs contiguous, no gap, overflow=0.
REQ-031 SHALL check: dout_ready low 10 cycles mid-block -> dout held stable, no sample lost or repeated.
REQ-032 SHALL check: dout_ready=0 while three full blocks stream -> first 128 stored, block 3 dropped, overflow=1 from sample 128 until rst.
REQ-033 SHALL check: rst after 30 samples, then a full block of -5 -> 64 outputs of -5 (DC_DIFF off) or DC -5 then 0 on next block of -5 (DC_DIFF on).
REQ-034 SHALL check: DC values 127 then -128 with ZIGZAG_DC_DIFF_EN -> dout index 0 = 127, then -255.
